// File: rtl/tick_scheduler.sv
// Multi-channel tick-enable generator: per-channel period counters loaded via a valid/ready config port.
// Optional TICK_SHADOW_UPDATE_EN: retuning a running periodic channel takes effect at its next terminal count.
module tick_scheduler #(
  parameter int Channels    = 4,
  parameter int ChannelBits = 2,
  parameter int BitsNumber  = 20
) (
  input  logic                   InputCLK,
  input  logic                   ResetN,
  input  logic                   CfgValid,
  output logic                   CfgReady,
  input  logic [ChannelBits-1:0] CfgChannel,
  input  logic [BitsNumber-1:0]  CfgPeriod,
  input  logic                   CfgEnable,
  input  logic                   CfgOneShot,
  output logic                   CfgError,
  output logic [Channels-1:0]    Tick,
  output logic [Channels-1:0]    Active
);

  typedef enum logic {IDLE = 1'b0, APPLY = 1'b1} state_e;

  state_e                 state_q;
  logic                   ready_q, err_q, en_q, os_q;
  logic [ChannelBits-1:0] ch_q;
  logic [BitsNumber-1:0]  per_req_q;
  logic                   ch_ok, req_ok;

  logic [BitsNumber-1:0]  cnt_q [Channels];
  logic [BitsNumber-1:0]  per_q [Channels];
  logic [Channels-1:0]    oneshot_q, active_q, tick_q;
  logic [Channels-1:0]    hit, term, shd;
`ifdef TICK_SHADOW_UPDATE_EN
  logic [BitsNumber-1:0]  shadow_q [Channels];
  logic [Channels-1:0]    pend_q;
`endif

  assign ch_ok    = int'(ch_q) < Channels;
  assign req_ok   = en_q && (per_req_q != '0);
  assign CfgReady = ready_q;
  assign CfgError = err_q;
  assign Tick     = tick_q;
  assign Active   = active_q;

  always_ff @(posedge InputCLK or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
      ch_q      <= '0;
      per_req_q <= '0;
      en_q      <= 1'b0;
      os_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (CfgValid) begin
            ch_q      <= CfgChannel;
            per_req_q <= CfgPeriod;
            en_q      <= CfgEnable;
            os_q      <= CfgOneShot;
            state_q   <= APPLY;
            ready_q   <= 1'b0;
          end
        end
        APPLY: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          err_q   <= !ch_ok || (en_q && (per_req_q == '0));
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // shd marks a retune of a running periodic channel that must not restart its counter
  always_comb begin
    hit  = '0;
    term = '0;
    shd  = '0;
    for (int i = 0; i < Channels; i++) begin
      hit[i]  = (state_q == APPLY) && ch_ok && (ch_q == ChannelBits'(i));
      term[i] = active_q[i] && (cnt_q[i] == per_q[i] - BitsNumber'(1));
`ifdef TICK_SHADOW_UPDATE_EN
      shd[i]  = hit[i] && req_ok && !os_q && active_q[i] && !oneshot_q[i];
`endif
    end
  end

  always_ff @(posedge InputCLK or negedge ResetN) begin
    if (!ResetN) begin
      cnt_q     <= '{default: '0};
      per_q     <= '{default: '0};
      oneshot_q <= '0;
      active_q  <= '0;
      tick_q    <= '0;
`ifdef TICK_SHADOW_UPDATE_EN
      shadow_q  <= '{default: '0};
      pend_q    <= '0;
`endif
    end else begin
      for (int i = 0; i < Channels; i++) begin
        if (hit[i] && !shd[i]) begin
          // a direct apply overrides any terminal count on the same edge
          tick_q[i]   <= 1'b0;
          cnt_q[i]    <= '0;
          active_q[i] <= req_ok;
          if (req_ok) begin
            per_q[i]     <= per_req_q;
            oneshot_q[i] <= os_q;
          end
`ifdef TICK_SHADOW_UPDATE_EN
          pend_q[i] <= 1'b0;
`endif
        end else if (active_q[i]) begin
          if (term[i]) begin
            cnt_q[i]  <= '0;
            tick_q[i] <= 1'b1;
            if (oneshot_q[i]) active_q[i] <= 1'b0;
`ifdef TICK_SHADOW_UPDATE_EN
            if (shd[i])         per_q[i] <= per_req_q;
            else if (pend_q[i]) per_q[i] <= shadow_q[i];
            pend_q[i] <= 1'b0;
`endif
          end else begin
            cnt_q[i]  <= cnt_q[i] + BitsNumber'(1);
            tick_q[i] <= 1'b0;
`ifdef TICK_SHADOW_UPDATE_EN
            if (shd[i]) begin
              shadow_q[i] <= per_req_q;
              pend_q[i]   <= 1'b1;
            end
`endif
          end
        end else begin
          tick_q[i] <= 1'b0;
        end
      end
    end
  end

endmodule
